// File: rtl/sobel_conv.sv
// sobel_conv: streaming 3x3 Sobel gradient over a raster-order 8-bit grayscale image.
// Two WIDTH-deep line buffers plus two registered window columns and the incoming column
// form the 3x3 neighbourhood; the gradient is registered one cycle after the completing pixel.
//
// Ports:
//   clk       - clock, all state updates on the rising edge
//   rst       - asynchronous active-high reset
//   in_valid  - in_pixel carries a pixel this cycle (no backpressure)
//   in_sof    - start of frame, qualified by in_valid; forces the pixel to position (0,0)
//   in_pixel  - unsigned 8-bit pixel
//   out_valid - out_data carries a gradient this cycle
//   out_data  - signed 12-bit gradient (Gx when DIR=0, Gy when DIR=1), held while out_valid=0
//   out_last  - marks the gradient produced by the frame's final pixel
module sobel_conv #(
  parameter int unsigned WIDTH  = 640,
  parameter int unsigned HEIGHT = 480,
  parameter int unsigned DIR    = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        in_sof,
  input  logic [7:0]  in_pixel,
  output logic        out_valid,
  output logic [11:0] out_data,
  output logic        out_last
);

  localparam int unsigned ColW = $clog2(WIDTH);
  localparam int unsigned RowW = $clog2(HEIGHT);

  logic [ColW-1:0] col_q, col_d, col_cur;
  logic [RowW-1:0] row_q, row_d, row_cur;

  // lb_top_q holds line row-2, lb_mid_q holds line row-1, indexed by column.
  logic [7:0] lb_top_q [WIDTH];
  logic [7:0] lb_mid_q [WIDTH];

  // Two older window columns, [row][col]; col 0 is the leftmost (col-2), col 1 is col-1.
  logic [7:0] win_q [3][2];

  logic [7:0]  col_top, col_mid, col_bot;
  logic        win_full;
  logic [9:0]  pos_sum, neg_sum;
  logic [11:0] grad;

  logic        out_valid_q, out_valid_d;
  logic [11:0] out_data_q, out_data_d;
  logic        out_last_q, out_last_d;

  // Position of the pixel being accepted; start-of-frame overrides the counters.
  always_comb begin
    col_cur = in_sof ? '0 : col_q;
    row_cur = in_sof ? '0 : row_q;
    col_d   = col_q;
    row_d   = row_q;
    if (in_valid) begin
      if (col_cur == ColW'(WIDTH - 1)) begin
        col_d = '0;
        row_d = (row_cur == RowW'(HEIGHT - 1)) ? '0 : row_cur + 1'b1;
      end else begin
        col_d = col_cur + 1'b1;
        row_d = row_cur;
      end
    end
  end

  // Incoming (rightmost) window column.
  always_comb begin
    col_top = lb_top_q[col_cur];
    col_mid = lb_mid_q[col_cur];
    col_bot = in_pixel;
  end

  // Row/column gate: stale line-buffer or window data is only ever present when this is low.
  assign win_full = (row_cur >= RowW'(2)) && (col_cur >= ColW'(2));

  always_comb begin
    if (DIR == 0) begin
      // Right column minus left column.
      pos_sum = {2'b00, col_top} + {1'b0, col_mid, 1'b0} + {2'b00, col_bot};
      neg_sum = {2'b00, win_q[0][0]} + {1'b0, win_q[1][0], 1'b0} + {2'b00, win_q[2][0]};
    end else begin
      // Bottom row minus top row.
      pos_sum = {2'b00, win_q[2][0]} + {1'b0, win_q[2][1], 1'b0} + {2'b00, col_bot};
      neg_sum = {2'b00, win_q[0][0]} + {1'b0, win_q[0][1], 1'b0} + {2'b00, col_top};
    end
    // Both sums are at most 1020, so the 12-bit difference is exact.
    grad = {2'b00, pos_sum} - {2'b00, neg_sum};
  end

  always_comb begin
    out_valid_d = in_valid && win_full;
    out_data_d  = out_valid_d ? grad : out_data_q;
    out_last_d  = out_valid_d && (row_cur == RowW'(HEIGHT - 1))
                              && (col_cur == ColW'(WIDTH - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  // Pixel storage is not reset; the window gate keeps it from reaching the outputs until refilled.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      lb_top_q[col_cur] <= col_mid;
      lb_mid_q[col_cur] <= in_pixel;
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= win_q[r][1];
      end
      win_q[0][1] <= col_top;
      win_q[1][1] <= col_mid;
      win_q[2][1] <= col_bot;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_sobel_conv.sv
// tb_sobel_conv: directed bench for sobel_conv on a 4x4 image, with one Gx and one Gy
// instance driven by the same pixel stream. Each accepted pixel is followed by a check of
// both instances one clock later.
module tb_sobel_conv;

  localparam int W = 4;
  localparam int H = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_sof;
  logic [7:0]  in_pixel;
  logic        gx_valid, gx_last, gy_valid, gy_last;
  logic [11:0] gx_data, gy_data;

  int          n_vec = 0;
  int          n_err = 0;
  logic [11:0] held_gx = '0;
  logic [11:0] held_gy = '0;

  always #5 clk = ~clk;

  sobel_conv #(.WIDTH(W), .HEIGHT(H), .DIR(0)) u_gx (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_pixel  (in_pixel),
    .out_valid (gx_valid),
    .out_data  (gx_data),
    .out_last  (gx_last)
  );

  sobel_conv #(.WIDTH(W), .HEIGHT(H), .DIR(1)) u_gy (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_pixel  (in_pixel),
    .out_valid (gy_valid),
    .out_data  (gy_data),
    .out_last  (gy_last)
  );

  // Test images: 0 flat 100, 1 ramp 10*col, 2 ramp 255-10*col, 3 rows 0-1 dark rows 2-3 bright,
  // 4 flat 255.
  function automatic logic [7:0] pix_of(input int kind, input int r, input int c);
    case (kind)
      0:       return 8'd100;
      1:       return 8'(10 * c);
      2:       return 8'(255 - 10 * c);
      3:       return (r >= 2) ? 8'd255 : 8'd0;
      default: return 8'd255;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs(input string tag, input logic ev, input logic el);
    chk({tag, " gx_valid"}, {11'b0, gx_valid}, {11'b0, ev});
    chk({tag, " gx_data"},  gx_data, held_gx);
    chk({tag, " gx_last"},  {11'b0, gx_last}, {11'b0, el});
    chk({tag, " gy_valid"}, {11'b0, gy_valid}, {11'b0, ev});
    chk({tag, " gy_data"},  gy_data, held_gy);
    chk({tag, " gy_last"},  {11'b0, gy_last}, {11'b0, el});
  endtask

  task automatic send(input logic [7:0] pix, input logic sof, input logic ev, input logic el,
                      input logic [11:0] egx, input logic [11:0] egy);
    @(negedge clk);
    in_valid = 1'b1;
    in_sof   = sof;
    in_pixel = pix;
    @(posedge clk);
    #1;
    if (ev) begin
      held_gx = egx;
      held_gy = egy;
    end
    chk_outputs("pixel", ev, el);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_pixel = 8'hA5;
    @(posedge clk);
    #1;
    chk_outputs("idle", 1'b0, 1'b0);
  endtask

  // Asserted away from any clock edge so the clear must be asynchronous.
  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    rst      = 1'b1;
    held_gx  = '0;
    held_gy  = '0;
    #1;
    chk_outputs("reset", 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Sends npix pixels of an image starting at (0,0); egx/egy are the hand-derived gradients
  // every complete window of that image must produce.
  task automatic frame(input int kind, input logic sof, input int npix, input logic gaps,
                       input logic [11:0] egx, input logic [11:0] egy);
    for (int idx = 0; idx < npix; idx++) begin
      int r;
      int c;
      r = idx / W;
      c = idx % W;
      send(pix_of(kind, r, c), sof && (idx == 0), (r >= 2) && (c >= 2),
           (r == H - 1) && (c == W - 1), egx, egy);
      if (gaps && (idx != npix - 1)) begin
        repeat ($urandom_range(1, 3)) idle();
      end
    end
  endtask

  initial begin
    rst      = 1'b0;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_pixel = 8'd0;
    #1;
    rst = 1'b1;
    #1;
    chk_outputs("power_on_reset", 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Flat image: no gradient in either direction.
    frame(0, 1'b1, 16, 1'b0, 12'd0, 12'd0);
    // Rising ramp: Gx = 4*20 = 80.
    frame(1, 1'b1, 16, 1'b0, 12'd80, 12'd0);
    // Falling ramp: Gx = -80.
    frame(2, 1'b1, 16, 1'b0, 12'hFB0, 12'd0);
    // Horizontal edge: Gy = 4*255 = 1020.
    frame(3, 1'b1, 16, 1'b0, 12'd0, 12'd1020);
    // Rising ramp with random idle gaps: same values, out_valid only right after each pixel.
    frame(1, 1'b1, 16, 1'b1, 12'd80, 12'd0);

    // out_valid/out_last are high from the last pixel here; reset must clear them at once.
    do_reset();

    // Partial frame, reset, then a full frame without start-of-frame.
    frame(1, 1'b0, 7, 1'b0, 12'd0, 12'd0);
    do_reset();
    frame(1, 1'b0, 16, 1'b0, 12'd80, 12'd0);

    // Five pixels of a bright frame, then start-of-frame on the sixth pixel.
    frame(4, 1'b1, 5, 1'b0, 12'd0, 12'd0);
    frame(1, 1'b1, 16, 1'b0, 12'd80, 12'd0);

    idle();
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
